data_mem_bank: RTL and testbench
================================

// Module: data_mem_bank
// PURPOSE
//  Parametrised data memory for the CSE141L core. Successor to the fixed 8-bit
//  store: width, depth and read latency are parametrised. Adds a hardware
//  clear sequencer, because an async reset cannot clear the array. Sits on
//  the core's load/store path. Busy stalls the core while clearing.
// PARAMETERS
//  AW        8      address width; depth = 2**AW words
//  DW        8      data word width (bits)
//  REG_READ  0      0: combinational read; 1: registered read, 1-cycle latency
//  CLR_VAL   '0     DW-bit value written to every word by the clear sweep
// PORTS
//  CLK          in   1    clock, all state updates on posedge
//  RST_N        in   1    asynchronous, active-low reset
//  DataAddress  in   AW   load/store address
//  ReadMem      in   1    read enable (REG_READ=1 only; ignored when REG_READ=0)
//  WriteMem     in   1    write enable
//  DataIn       in   DW   store data
//  ClearMem     in   1    request a full-array clear sweep (level, sampled in IDLE)
//  DataOut      out  DW   load data
//  Busy         out  1    1 while the clear sweep runs; core accesses are ignored
//  AccessErr    out  1    1-cycle pulse: ReadMem/WriteMem was asserted while Busy
// BEHAVIOUR
//  Reset (RST_N=0, async): state=CLEAR, ClrPtr=0, Busy=1, AccessErr=0,
//   DataOut reg=0 (REG_READ=1). The array is not reset directly.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each cycle writes CLR_VAL to mem[ClrPtr], then ClrPtr++.
//    When ClrPtr==2**AW-1, that write completes and the next state is IDLE.
//    A sweep takes exactly 2**AW cycles. Busy=1 throughout. ClrPtr wraps to 0.
//   IDLE: Busy=0. WriteMem=1 -> mem[DataAddress]<=DataIn at posedge.
//    ClearMem=1 -> CLEAR next cycle with ClrPtr=0. A WriteMem in the same cycle
//    still commits.
//  Busy is a registered output: Busy = (state==CLEAR).
//  Read, REG_READ=0: DataOut = mem[DataAddress] combinationally, always valid.
//  Read, REG_READ=1: ReadMem=1 in IDLE -> DataOut = mem[DataAddress] after the next
//   posedge. DataOut holds its value when ReadMem=0 or while Busy.
//   Read and write to the same address in the same cycle is write-first:
//   DataOut shows the new DataIn.
//  While Busy: WriteMem and ReadMem have no effect.
//   AccessErr <= (ReadMem|WriteMem) & Busy (registered, 1 cycle later).
//  ClearMem while in CLEAR: ignored. The sweep does not restart.
//  RST_N asserted mid-sweep: the sweep restarts from ClrPtr=0.
//  Address is full range 0..2**AW-1. There is no out-of-range case.
// STRUCTURE
//  data_mem_pkg: typedef enum logic {S_CLEAR, S_IDLE} mem_state_t;
//   shared clear-value default constant.
//  Sub-module data_mem_array: storage only, with one write port and one async
//   read port, parametrised AW/DW.
//  data_mem_bank owns the FSM, ClrPtr counter, write-port mux (sweep vs core),
//   read register and forwarding, and AccessErr.
// TESTING (AW=4, DW=8 unless noted)
//  1. Release RST_N -> Busy=1 for exactly 16 cycles, then 0.
//     All 16 addresses then read 8'h00.
//  2. REG_READ=0: write 8'hA5 @3, 8'h5A @15 -> combinational reads return A5 / 5A.
//     Address 0 is unchanged (00).
//  3. REG_READ=1: ReadMem @3 -> DataOut=A5 one cycle later, then holds.
//     Same-cycle write 8'h3C + read @7 -> DataOut=3C next cycle.
//  4. Fill memory, then ClearMem 1 cycle -> Busy for 16 cycles, all words 00.
//     WriteMem during Busy -> AccessErr pulse, no write.
//  5. Assert RST_N=0 at sweep cycle 9, release -> full 16-cycle sweep restarts.
//     ClearMem during CLEAR does not extend Busy.
//  6. CLR_VAL=8'hFF, DW=16, AW=3 -> after reset all 8 words read 16'h00FF.
//     Full-width write 16'hBEEF reads back intact.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the parametrised data memory bank.
package data_mem_pkg;

  typedef enum logic {S_CLEAR, S_IDLE} mem_state_t;

  // Truncated to DW at the point of use.
  localparam logic [63:0] CLR_VAL_DEFAULT = '0;

endpackage

// File: rtl/data_mem_array.sv
// Storage only: one synchronous write port, one asynchronous read port, no reset.
module data_mem_array #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_bank.sv
// Data memory for the core load/store path, with a hardware clear sweep that
// stalls the core (Busy) while every word is overwritten with CLR_VAL.
//
// state   | meaning
// S_CLEAR | sweep writes CLR_VAL to mem[ClrPtr] each cycle; core access ignored
// S_IDLE  | core loads/stores served; ClearMem starts a new sweep
module data_mem_bank
  import data_mem_pkg::*;
#(
  parameter int unsigned   AW       = 8,
  parameter int unsigned   DW       = 8,
  parameter bit            REG_READ = 1'b0,
  parameter logic [DW-1:0] CLR_VAL  = DW'(CLR_VAL_DEFAULT)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] DataAddress,
  input  logic          ReadMem,
  input  logic          WriteMem,
  input  logic [DW-1:0] DataIn,
  input  logic          ClearMem,
  output logic [DW-1:0] DataOut,
  output logic          Busy,
  output logic          AccessErr
);

  mem_state_t    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          access_err_q, access_err_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rd_data;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = DataAddress;
    mem_wdata = DataIn;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = CLR_VAL;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == '1) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        mem_we = WriteMem;
        if (ClearMem) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign Busy         = (state_q == S_CLEAR);
  assign access_err_d = (ReadMem | WriteMem) & Busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_CLEAR;
      clr_ptr_q    <= '0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      access_err_q <= access_err_d;
    end
  end

  assign AccessErr = access_err_q;

  data_mem_array #(
    .AW(AW),
    .DW(DW)
  ) u_array (
    .clk_i  (CLK),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(DataAddress),
    .rdata_o(rd_data)
  );

  if (REG_READ) begin : g_reg_read
    logic [DW-1:0] dout_q, dout_d;

    // Read and write share DataAddress, so a same-cycle store is forwarded.
    always_comb begin
      dout_d = dout_q;
      if ((state_q == S_IDLE) && ReadMem) begin
        dout_d = WriteMem ? DataIn : rd_data;
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign DataOut = dout_q;
  end else begin : g_comb_read
    assign DataOut = rd_data;
  end

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed bench: two AW=4/DW=8 banks (comb and registered read) on shared
// stimulus, plus an AW=3/DW=16 bank with a non-zero clear value.
module tb_data_mem_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] addr;
  logic       re, we, clr;
  logic [7:0] din;
  logic [7:0] dout0, dout1;
  logic       busy0, busy1, err0, err1;

  logic [2:0]  addr2;
  logic        re2, we2, clr2;
  logic [15:0] din2, dout2;
  logic        busy2, err2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_mem_bank #(.AW(4), .DW(8), .REG_READ(1'b0)) u0 (
    .CLK(clk), .RST_N(rst_n), .DataAddress(addr), .ReadMem(re), .WriteMem(we),
    .DataIn(din), .ClearMem(clr), .DataOut(dout0), .Busy(busy0), .AccessErr(err0)
  );

  data_mem_bank #(.AW(4), .DW(8), .REG_READ(1'b1)) u1 (
    .CLK(clk), .RST_N(rst_n), .DataAddress(addr), .ReadMem(re), .WriteMem(we),
    .DataIn(din), .ClearMem(clr), .DataOut(dout1), .Busy(busy1), .AccessErr(err1)
  );

  data_mem_bank #(.AW(3), .DW(16), .REG_READ(1'b0), .CLR_VAL(16'h00FF)) u2 (
    .CLK(clk), .RST_N(rst_n), .DataAddress(addr2), .ReadMem(re2), .WriteMem(we2),
    .DataIn(din2), .ClearMem(clr2), .DataOut(dout2), .Busy(busy2), .AccessErr(err2)
  );

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Counts cycles with Busy high, starting with the current cycle; ClearMem is
  // dropped once clr_hold busy cycles have been seen.
  task automatic count_busy(input int clr_hold, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (n >= clr_hold) clr = 1'b0;
      if (!busy0) break;
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; addr = '0; re = 0; we = 0; clr = 0; din = '0;
    addr2 = '0; re2 = 0; we2 = 0; clr2 = 0; din2 = '0;

    vecs[0]  = '{1'b1, 1'b0, 4'd3,  8'hA5, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 4'd15, 8'h5A, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 4'd3,  8'h00, 8'hA5, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 4'd15, 8'h00, 8'h5A, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  8'h00, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 4'd3,  8'h00, 8'hA5, 8'hA5};
    vecs[6]  = '{1'b0, 1'b0, 4'd15, 8'h00, 8'h5A, 8'hA5};
    vecs[7]  = '{1'b1, 1'b1, 4'd7,  8'h3C, 8'h00, 8'h3C};
    vecs[8]  = '{1'b0, 1'b0, 4'd7,  8'h00, 8'h3C, 8'h3C};
    vecs[9]  = '{1'b0, 1'b1, 4'd15, 8'h00, 8'h5A, 8'h5A};
    vecs[10] = '{1'b1, 1'b1, 4'd3,  8'h11, 8'hA5, 8'h11};
    vecs[11] = '{1'b0, 1'b1, 4'd3,  8'h00, 8'h11, 8'h11};

    // Reset state and first sweep
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy0", busy0, 1);
    check("rst_busy1", busy1, 1);
    check("rst_err0", err0, 0);
    check("rst_dout1", dout1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_busy(0, n);
    check("reset_sweep_len", n, 16);
    check("busy1_after_sweep", busy1, 0);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("post_reset_word%0d", i), dout0, 8'h00);
    end

    // Table-driven load/store vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr; din = vecs[i].din;
      #1;
      check($sformatf("vec%0d_comb", i), dout0, vecs[i].exp0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_reg", i), dout1, vecs[i].exp1);
    end
    @(negedge clk);
    we = 0; re = 0;

    // Fill, then a one-cycle ClearMem
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we = 1; addr = 4'(i); din = 8'(i * 17 + 1);
    end
    @(negedge clk);
    we = 0; addr = 4'd9;
    #1;
    check("fill_word9", dout0, 8'h9A);
    clr = 1;
    @(posedge clk); #1;
    count_busy(1, n);
    check("clear_sweep_len", n, 16);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("cleared_word%0d", i), dout0, 8'h00);
    end

    // Store attempted in the last sweep cycle to an already-swept word
    @(negedge clk);
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    repeat (15) @(posedge clk);
    #1;
    check("last_cycle_busy", busy0, 1);
    we = 1; re = 1; addr = 4'd0; din = 8'h99;
    @(posedge clk); #1;
    we = 0; re = 0;
    check("busy_write_err0", err0, 1);
    check("busy_read_err1", err1, 1);
    check("busy_after_last", busy0, 0);
    check("busy_dout1_hold", dout1, 8'h11);
    check("busy_write_dropped", dout0, 8'h00);
    @(posedge clk); #1;
    check("err_one_cycle", err0, 0);

    // ClearMem held into the sweep does not extend it
    @(negedge clk);
    clr = 1;
    @(posedge clk); #1;
    count_busy(10, n);
    check("clear_held_len", n, 16);

    // Reset at sweep cycle 9 restarts the sweep
    @(negedge clk);
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midsweep_rst_busy", busy0, 1);
    check("midsweep_rst_err", err0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_busy(0, n);
    check("restart_sweep_len", n, 16);

    // Wide bank with non-zero clear value
    check("wide_busy", busy2, 0);
    for (int i = 0; i < 8; i++) begin
      addr2 = 3'(i);
      #1;
      check($sformatf("wide_clear_word%0d", i), dout2, 16'h00FF);
    end
    @(negedge clk);
    we2 = 1; addr2 = 3'd6; din2 = 16'hBEEF;
    @(posedge clk); #1;
    we2 = 0;
    #1;
    check("wide_write_beef", dout2, 16'hBEEF);
    addr2 = 3'd5;
    #1;
    check("wide_neighbor", dout2, 16'h00FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
